// File: rtl/isp_pkg.sv
// Shared types and quad-to-RGB conversion for the 2x2 Bayer debayer.
package isp_pkg;

  typedef enum logic [1:0] {
    RGGB = 2'd0,
    GRBG = 2'd1,
    GBRG = 2'd2,
    BGGR = 2'd3
  } bayer_pattern_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int unsigned PIX_MAX = 16;

  // Pixels arrive zero-extended to PIX_MAX; width selects the 8 MSBs kept.
  function automatic rgb888_t quad_to_rgb(
    input bayer_pattern_t     pattern,
    input logic [PIX_MAX-1:0] top0,
    input logic [PIX_MAX-1:0] top1,
    input logic [PIX_MAX-1:0] bot0,
    input logic [PIX_MAX-1:0] bot1,
    input int unsigned        width
  );
    logic [PIX_MAX-1:0] r;
    logic [PIX_MAX-1:0] g1;
    logic [PIX_MAX-1:0] g2;
    logic [PIX_MAX-1:0] b;
    logic [PIX_MAX:0]   g_sum;
    rgb888_t            rgb;
    case (pattern)
      RGGB:    begin r = top0; g1 = top1; g2 = bot0; b = bot1; end
      GRBG:    begin g1 = top0; r = top1; b = bot0; g2 = bot1; end
      GBRG:    begin g1 = top0; b = top1; r = bot0; g2 = bot1; end
      default: begin b = top0; g1 = top1; g2 = bot0; r = bot1; end
    endcase
    g_sum = {1'b0, g1} + {1'b0, g2};
    rgb.r = 8'(r >> (width - 8));
    rgb.g = 8'(g_sum >> (width - 7));
    rgb.b = 8'(b >> (width - 8));
    return rgb;
  endfunction

endpackage

// File: rtl/isp_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
module isp_line_buf #(
  parameter int unsigned DEPTH = 960,
  parameter int unsigned WIDTH = 20,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/isp_debayer_2x2.sv
// 2x2-quad Bayer to RGB888 converter: buffers even rows, emits one RGB pixel
// per column pair on odd rows with a fixed two-cycle latency.
module isp_debayer_2x2
  import isp_pkg::*;
#(
  parameter int unsigned PIX_WIDTH   = 10,
  parameter int unsigned NUM_LANE    = 2,
  parameter int unsigned LINE_LENGTH = 1920,
  localparam int unsigned OUT_LANE   = NUM_LANE / 2,
  localparam int unsigned DW         = NUM_LANE * PIX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_sof,
  input  logic                  in_sol,
  input  logic [1:0]            cfg_pattern,
  output logic                  out_valid,
  output logic [OUT_LANE*24-1:0] out_rgb,
  output logic                  out_sol,
  output logic                  out_sof,
  output logic                  err_overlong,
  input  logic                  err_clear
);

  localparam int unsigned LINE_BEATS = LINE_LENGTH / NUM_LANE;
  localparam int unsigned PW = $clog2(LINE_BEATS + 1);
  localparam int unsigned AW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  logic           parity_q;
  bayer_pattern_t pattern_q;
  logic [PW-1:0]  ptr_q;
  logic           sof_pend_q;

  logic           parity_eff;
  bayer_pattern_t pattern_eff;
  logic [PW-1:0]  ptr_eff;
  logic           overflow;
  logic           beat_ok;

  logic           s1_valid;
  logic           s1_sol;
  logic           s1_sof;
  bayer_pattern_t s1_pat;
  logic [DW-1:0]  s1_bot;
  logic [DW-1:0]  top_data;
  logic [OUT_LANE*24-1:0] rgb_next;

  // Row state as seen by the current beat, including its own SOF/SOL.
  always_comb begin
    parity_eff  = parity_q;
    pattern_eff = pattern_q;
    ptr_eff     = ptr_q;
    if (in_sof) begin
      parity_eff  = 1'b0;
      pattern_eff = bayer_pattern_t'(cfg_pattern);
    end else if (in_sol) begin
      parity_eff = ~parity_q;
    end
    if (in_sof || in_sol) ptr_eff = '0;
    overflow = in_valid && (ptr_eff >= PW'(LINE_BEATS));
    beat_ok  = in_valid && !overflow;
  end

  isp_line_buf #(
    .DEPTH (LINE_BEATS),
    .WIDTH (DW),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (beat_ok && !parity_eff),
    .wr_addr (ptr_eff[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (beat_ok && parity_eff),
    .rd_addr (ptr_eff[AW-1:0]),
    .rd_data (top_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q     <= 1'b0;
      pattern_q    <= RGGB;
      ptr_q        <= '0;
      sof_pend_q   <= 1'b0;
      s1_valid     <= 1'b0;
      s1_sol       <= 1'b0;
      s1_sof       <= 1'b0;
      s1_pat       <= RGGB;
      s1_bot       <= '0;
      err_overlong <= 1'b0;
    end else begin
      if (in_valid) begin
        parity_q  <= parity_eff;
        pattern_q <= pattern_eff;
        ptr_q     <= overflow ? ptr_eff : ptr_eff + PW'(1);
        if (in_sof) sof_pend_q <= 1'b1;
        else if (beat_ok && parity_eff) sof_pend_q <= 1'b0;
      end
      s1_valid <= beat_ok && parity_eff;
      s1_sol   <= in_sol;
      s1_sof   <= in_sol && sof_pend_q;
      s1_pat   <= pattern_eff;
      if (beat_ok && parity_eff) s1_bot <= in_data;
      if (overflow) err_overlong <= 1'b1;
      else if (err_clear) err_overlong <= 1'b0;
    end
  end

  always_comb begin
    rgb_next = '0;
    for (int unsigned k = 0; k < OUT_LANE; k++) begin
      rgb_next[k*24 +: 24] = quad_to_rgb(
        s1_pat,
        PIX_MAX'(top_data[(2*k)*PIX_WIDTH   +: PIX_WIDTH]),
        PIX_MAX'(top_data[(2*k+1)*PIX_WIDTH +: PIX_WIDTH]),
        PIX_MAX'(s1_bot[(2*k)*PIX_WIDTH     +: PIX_WIDTH]),
        PIX_MAX'(s1_bot[(2*k+1)*PIX_WIDTH   +: PIX_WIDTH]),
        PIX_WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_sol   <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_sol   <= s1_valid && s1_sol;
      out_sof   <= s1_valid && s1_sof;
      if (s1_valid) out_rgb <= rgb_next;
    end
  end

endmodule

// File: tb/tb_isp_debayer_2x2.sv
// Directed and randomised checks of isp_debayer_2x2 (10b/2-lane and 12b/4-lane).
module tb_isp_debayer_2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_sol = 1'b0;
  logic [1:0]  cfg_pattern = 2'd0;
  logic        err_clear = 1'b0;
  logic        out_valid;
  logic [23:0] out_rgb;
  logic        out_sol;
  logic        out_sof;
  logic        err_overlong;

  logic        d2_valid = 1'b0;
  logic [47:0] d2_data = '0;
  logic        d2_sof = 1'b0;
  logic        d2_sol = 1'b0;
  logic [1:0]  d2_cfg = 2'd0;
  logic        d2_clear = 1'b0;
  logic        d2_out_valid;
  logic [47:0] d2_out_rgb;
  logic        d2_out_sol;
  logic        d2_out_sof;
  logic        d2_err;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned row_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  isp_debayer_2x2 #(.PIX_WIDTH(10), .NUM_LANE(2), .LINE_LENGTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_sol(in_sol), .cfg_pattern(cfg_pattern),
    .out_valid(out_valid), .out_rgb(out_rgb), .out_sol(out_sol),
    .out_sof(out_sof), .err_overlong(err_overlong), .err_clear(err_clear));

  isp_debayer_2x2 #(.PIX_WIDTH(12), .NUM_LANE(4), .LINE_LENGTH(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_valid), .in_data(d2_data),
    .in_sof(d2_sof), .in_sol(d2_sol), .cfg_pattern(d2_cfg),
    .out_valid(d2_out_valid), .out_rgb(d2_out_rgb), .out_sol(d2_out_sol),
    .out_sof(d2_out_sof), .err_overlong(d2_err), .err_clear(d2_clear));

  typedef struct {
    logic [23:0] rgb;
    logic        sol;
    logic        sof;
    int unsigned cyc;
  } obs_t;

  typedef struct {
    logic [47:0] rgb;
    logic        sol;
    logic        sof;
  } obs2_t;

  typedef struct {
    logic [1:0]  pat;
    logic [19:0] top;
    logic [19:0] bot;
    logic [23:0] exp_rgb;
  } vec_t;

  obs_t  obs_q[$];
  obs2_t obs2_q[$];
  obs2_t exp2_q[$];

  always @(negedge clk) begin
    if (out_valid) obs_q.push_back('{out_rgb, out_sol, out_sof, cyc});
    if (d2_out_valid) obs2_q.push_back('{d2_out_rgb, d2_out_sol, d2_out_sof});
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic beat(input logic sof, input logic sol, input logic [19:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_sof = sof; in_sol = sol; in_data = d;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'b0; in_sol = 1'b0;
    end
  endtask

  task automatic row(input logic sof, input int unsigned n, input logic [19:0] d);
    for (int unsigned i = 0; i < n; i++) begin
      beat(sof && (i == 0), i == 0, d);
      if (i == 0) row_cyc = cyc;
    end
  endtask

  task automatic check_all(input string name, input int unsigned n, input logic [23:0] rgb);
    chk({name, "_count"}, 64'(obs_q.size()), 64'(n));
    foreach (obs_q[i]) chk({name, "_rgb"}, 64'(obs_q[i].rgb), 64'(rgb));
  endtask

  // Reference: R/B keep the top 8 bits, G is the truncated mean of both greens.
  function automatic logic [23:0] ref_rgb(input int unsigned pat, input int unsigned t0,
                                          input int unsigned t1, input int unsigned b0,
                                          input int unsigned b1);
    int unsigned r, g, b;
    case (pat)
      0:       begin r = t0; g = t1 + b0; b = b1; end
      1:       begin r = t1; g = t0 + b1; b = b0; end
      2:       begin r = b0; g = t0 + b1; b = t1; end
      default: begin r = b1; g = t1 + b0; b = t0; end
    endcase
    return {8'(r / 16), 8'(g / 32), 8'(b / 16)};
  endfunction

  localparam logic [19:0] TOP = {10'h200, 10'h3FC};
  localparam logic [19:0] BOT = {10'h004, 10'h100};

  initial begin
    vec_t        vecs[6];
    logic [47:0] even_row[4];
    logic [47:0] d;
    int unsigned odd_cyc;
    int unsigned nsol, nsof;

    vecs[0] = '{2'd0, {10'h200, 10'h3FC}, {10'h004, 10'h100}, 24'hFF6001};
    vecs[1] = '{2'd1, {10'h3FF, 10'h100}, {10'h0FF, 10'h000}, 24'hFF3F00};
    vecs[2] = '{2'd2, {10'h155, 10'h3FF}, {10'h3FF, 10'h2AA}, 24'hAAFF55};
    vecs[3] = '{2'd3, {10'h007, 10'h003}, {10'h3FB, 10'h008}, 24'hFE0100};
    vecs[4] = '{2'd0, 20'h00000, 20'h00000, 24'h000000};
    vecs[5] = '{2'd0, {10'h007, 10'h004}, {10'h003, 10'h000}, 24'h010000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_sol, out_sof, err_overlong, out_rgb}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Single-quad table: each vector is a 2-row frame of one beat per row.
    foreach (vecs[i]) begin
      cfg_pattern = vecs[i].pat;
      obs_q.delete();
      row(1'b1, 1, vecs[i].top);
      row(1'b0, 1, vecs[i].bot);
      idle(4);
      chk("vec_count", 64'(obs_q.size()), 64'd1);
      if (obs_q.size() >= 1) begin
        chk("vec_rgb", 64'(obs_q[0].rgb), 64'(vecs[i].exp_rgb));
        chk("vec_markers", {obs_q[0].sol, obs_q[0].sof}, 2'b11);
      end
    end

    // Full line: latency, back-to-back output and markers.
    cfg_pattern = 2'd0;
    obs_q.delete();
    row(1'b1, 4, TOP);
    row(1'b0, 4, BOT);
    odd_cyc = row_cyc;
    idle(4);
    check_all("full", 4, 24'hFF6001);
    if (obs_q.size() == 4) begin
      chk("latency", 64'(obs_q[0].cyc - odd_cyc), 64'd2);
      chk("contiguous", 64'(obs_q[3].cyc - obs_q[0].cyc), 64'd3);
      foreach (obs_q[i]) chk("full_markers", {obs_q[i].sol, obs_q[i].sof}, (i == 0) ? 2'b11 : 2'b00);
    end

    // Pattern latched at SOF; mid-frame change waits for next frame.
    cfg_pattern = 2'd3;
    obs_q.delete();
    row(1'b1, 4, TOP);
    cfg_pattern = 2'd0;
    row(1'b0, 4, BOT);
    row(1'b0, 4, TOP);
    row(1'b0, 4, BOT);
    idle(4);
    check_all("bggr", 8, 24'h0160FF);
    nsol = 0; nsof = 0;
    foreach (obs_q[i]) begin nsol += obs_q[i].sol; nsof += obs_q[i].sof; end
    chk("bggr_sol_count", 64'(nsol), 64'd2);
    chk("bggr_sof_count", 64'(nsof), 64'd1);
    obs_q.delete();
    row(1'b1, 4, TOP);
    row(1'b0, 4, BOT);
    idle(4);
    check_all("next_frame_rggb", 4, 24'hFF6001);

    // Overlong odd row: extra beats dropped, sticky error.
    chk("err_initial", 64'(err_overlong), 64'd0);
    obs_q.delete();
    row(1'b1, 4, TOP);
    row(1'b0, 6, BOT);
    idle(4);
    check_all("overlong", 4, 24'hFF6001);
    chk("err_set", 64'(err_overlong), 64'd1);
    obs_q.delete();
    row(1'b1, 4, TOP);
    row(1'b0, 4, BOT);
    idle(4);
    check_all("after_overlong", 4, 24'hFF6001);
    chk("err_sticky", 64'(err_overlong), 64'd1);
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    chk("err_cleared", 64'(err_overlong), 64'd0);
    // Clear and a fresh overflow in the same cycle: overflow wins.
    row(1'b1, 4, TOP);
    beat(1'b0, 1'b0, TOP);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    idle(1);
    chk("err_clear_vs_overflow", 64'(err_overlong), 64'd1);
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    chk("err_cleared2", 64'(err_overlong), 64'd0);

    // Three-row frame then new frame: row 2 and new row 0 silent.
    obs_q.delete();
    row(1'b1, 4, TOP);
    row(1'b0, 4, BOT);
    row(1'b0, 4, TOP);
    row(1'b1, 4, TOP);
    idle(4);
    check_all("three_row", 4, 24'hFF6001);

    // Short odd row: only its own beats produce output.
    obs_q.delete();
    row(1'b1, 4, TOP);
    row(1'b0, 2, BOT);
    idle(4);
    check_all("short_odd", 2, 24'hFF6001);

    // Reset on the second beat of an odd row.
    obs_q.delete();
    row(1'b1, 4, TOP);
    beat(1'b0, 1'b1, BOT);
    beat(1'b0, 1'b0, BOT);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_outputs", {out_valid, out_sol, out_sof, err_overlong, out_rgb}, '0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
    beat(1'b0, 1'b0, BOT);
    beat(1'b0, 1'b0, BOT);
    idle(4);
    chk("post_reset_silent", 64'(obs_q.size()), 64'd0);
    row(1'b1, 4, TOP);
    row(1'b0, 4, BOT);
    idle(4);
    check_all("post_reset_frame", 4, 24'hFF6001);
    if (obs_q.size() >= 1) chk("post_reset_sof", 64'(obs_q[0].sof), 64'd1);

    // 12-bit, 4-lane instance: random frames with gaps, all patterns.
    for (int unsigned f = 0; f < 4; f++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            d2_valid = 1'b0; d2_sof = 1'b0; d2_sol = 1'b0;
            d2_cfg = 2'($urandom_range(0, 3));
          end
          d = 48'({$urandom(), $urandom()});
          @(negedge clk);
          d2_cfg = (r == 0 && b == 0) ? 2'(f) : 2'($urandom_range(0, 3));
          d2_valid = 1'b1;
          d2_sof = (r == 0 && b == 0);
          d2_sol = (b == 0);
          d2_data = d;
          if (r % 2 == 0) even_row[b] = d;
          else begin
            obs2_t e;
            e.sol = (b == 0);
            e.sof = (b == 0 && r == 1);
            for (int unsigned q = 0; q < 2; q++)
              e.rgb[q*24 +: 24] = ref_rgb(f,
                32'(even_row[b][(2*q)*12 +: 12]), 32'(even_row[b][(2*q+1)*12 +: 12]),
                32'(d[(2*q)*12 +: 12]), 32'(d[(2*q+1)*12 +: 12]));
            exp2_q.push_back(e);
          end
        end
      end
    end
    @(negedge clk);
    d2_valid = 1'b0; d2_sof = 1'b0; d2_sol = 1'b0;
    repeat (4) @(negedge clk);
    chk("rand_count", 64'(obs2_q.size()), 64'(exp2_q.size()));
    for (int unsigned i = 0; i < exp2_q.size() && i < obs2_q.size(); i++) begin
      chk("rand_rgb", 64'(obs2_q[i].rgb), 64'(exp2_q[i].rgb));
      chk("rand_markers", {obs2_q[i].sol, obs2_q[i].sof}, {exp2_q[i].sol, exp2_q[i].sof});
    end
    chk("rand_err", 64'(d2_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
